// File: rtl/button_encoder_pkg.sv
// Shared types and helpers for the button encoder: FSM states, widths,
// one-hot detection and index encoding of the debounced button vector.
package button_encoder_pkg;

  localparam int CODE_W      = 2;
  localparam int NUM_BUTTONS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  function automatic logic is_onehot(input logic [NUM_BUTTONS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [NUM_BUTTONS-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      if (v[i]) r = CODE_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/button_encoder_debounce_bit.sv
// One button bit: 2-flop synchronizer, saturating disagreement counter and
// the accepted (debounced) level.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      // level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle
      if (sync[1] != level) begin
        if (cnt >= LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else if (cnt != MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_encoder.sv
// Debounces four player buttons and reports single presses as a binary code
// with a one-cycle valid. Optional err pulse on multi-press under
// BUTTON_ENCODER_MULTI_ERR_EN.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic [CODE_W-1:0]      code,
  output logic                   valid,
  output logic                   busy
`ifdef BUTTON_ENCODER_MULTI_ERR_EN
  ,
  output logic                   err
`endif
);

  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] db_q;
  state_t                 state, state_nxt;
  logic                   valid_nxt;
  logic [CODE_W-1:0]      code_nxt;
`ifdef BUTTON_ENCODER_MULTI_ERR_EN
  logic                   err_nxt;
`endif

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BUTTONS-1:0] (
    .clk   (clk),
    .rst   (rst),
    .din   (button),
    .level (level)
  );

  // db_q retimes the debounced vector so decode and busy share one stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      db_q  <= '0;
      valid <= 1'b0;
      code  <= '0;
      busy  <= 1'b0;
`ifdef BUTTON_ENCODER_MULTI_ERR_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      db_q  <= level;
      valid <= valid_nxt;
      code  <= code_nxt;
      busy  <= |db_q;
`ifdef BUTTON_ENCODER_MULTI_ERR_EN
      err   <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    code_nxt  = code;
`ifdef BUTTON_ENCODER_MULTI_ERR_EN
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (is_onehot(db_q)) begin
          valid_nxt = 1'b1;
          code_nxt  = encode(db_q);
          state_nxt = HELD;
        end else if (db_q != '0) begin
          state_nxt = HELD;
`ifdef BUTTON_ENCODER_MULTI_ERR_EN
          err_nxt   = 1'b1;
`endif
        end
      end
      HELD: begin
        if (db_q == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
